// File: rtl/debounce_pkg.sv
// Shared types for the pushbutton debouncer: FSM state encoding and
// the helper that maps a state to its debounced level.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_e;

  // Debounced level only follows the accepted state, not the pending one.
  function automatic logic db_level(input db_state_e s);
    return (s == ONE) || (s == WAIT0);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: counts 0..N and pulses tick for the one cycle at N.
// Reusable by any top that needs a slow periodic strobe.
module tick_gen #(
  parameter int N = 999_999
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (N > 0) ? $clog2(N + 1) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(N));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton debouncer: 2-flop synchronizer, tick-sampled 4-state FSM,
// registered level plus single-cycle rise/fall strobes.
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int N = 999_999,
  parameter int M = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_db,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int SW = $clog2(M + 1);

  logic          sync1, sync2;
  logic          tick;
  db_state_e     state_q, state_d;
  logic [SW-1:0] stable_q, stable_d;
  logic          db_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  tick_gen #(.N(N)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // A reversal is checked before the tick so a coincident tick is dropped.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    case (state_q)
      ZERO: begin
        if (sync2) begin
          state_d  = WAIT1;
          stable_d = '0;
        end
      end
      WAIT1: begin
        if (!sync2) begin
          state_d = ZERO;
        end else if (tick) begin
          if (stable_q == SW'(M - 1)) begin
            state_d  = ONE;
            stable_d = '0;
          end else begin
            stable_d = stable_q + SW'(1);
          end
        end
      end
      ONE: begin
        if (!sync2) begin
          state_d  = WAIT0;
          stable_d = '0;
        end
      end
      WAIT0: begin
        if (sync2) begin
          state_d = ONE;
        end else if (tick) begin
          if (stable_q == SW'(M - 1)) begin
            state_d  = ZERO;
            stable_d = '0;
          end else begin
            stable_d = stable_q + SW'(1);
          end
        end
      end
      default: begin
        state_d  = ZERO;
        stable_d = '0;
      end
    endcase
    db_d = db_level(state_d);
  end

  // Strobes are derived from the registered level so they align with its edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ZERO;
      stable_q <= '0;
      btn_db   <= 1'b0;
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      btn_db   <= db_d;
      btn_rise <= db_d & ~btn_db;
      btn_fall <= ~db_d & btn_db;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (N=4, M=3): expected pulses with their
// latency windows are queued at each step and retired by the output monitor.
module tb_btn_debounce;
  import debounce_pkg::*;

  localparam int N  = 4;
  localparam int M  = 3;
  localparam int LO = (M - 1) * (N + 1) + 3;
  localparam int HI = M * (N + 1) + 2;

  typedef struct {
    logic rise;
    int   lo;
    int   hi;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_in;
  logic btn_db, btn_rise, btn_fall;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic db_prev = 1'b0;
  logic rise_prev = 1'b0;
  logic fall_prev = 1'b0;

  btn_debounce #(.N(N), .M(M)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_in   (btn_in),
    .btn_db   (btn_db),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Edge k (first sampling edge of the new level) is the next posedge.
  task automatic push(input logic r);
    sb.push_back('{rise: r, lo: cyc + 1 + LO, hi: cyc + 1 + HI});
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic step(input logic v);
    @(posedge clk); #1;
    btn_in = v;
  endtask

  // Output monitor: reset values, pulse exclusivity/width/alignment, scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_outputs", {btn_db, btn_rise, btn_fall}, 0);
    end else begin
      chk("rise_fall_excl", int'(btn_rise && btn_fall), 0);
      chk("rise_width", int'(btn_rise && rise_prev), 0);
      chk("fall_width", int'(btn_fall && fall_prev), 0);
      chk("rise_on_db_edge", btn_rise, int'(btn_db && !db_prev));
      chk("fall_on_db_edge", btn_fall, int'(!btn_db && db_prev));
      if (btn_rise || btn_fall) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", int'(btn_rise) * 2 + int'(btn_fall), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pulse_kind_rise", btn_rise, e.rise);
          chk("pulse_after_lo", int'(cyc >= e.lo), 1);
          chk("pulse_before_hi", int'(cyc <= e.hi), 1);
        end
      end
    end
    db_prev   = btn_db;
    rise_prev = btn_rise;
    fall_prev = btn_fall;
  end

  initial begin
    int n;
    reset_n = 1'b1;
    btn_in  = 1'b1;
    #1 reset_n = 1'b0;

    // Reset held 3 cycles with button high, then synchronous release.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'(dut.state_q), int'(ZERO));
    reset_n = 1'b1;
    push(1'b1);
    wait_sb("rise_after_reset", 30);
    chk("db_high_after_reset", btn_db, 1);

    // Clean fall, clean rise, clean fall.
    step(1'b0); push(1'b0);
    wait_sb("clean_fall", 30);
    chk("db_low_after_fall", btn_db, 0);
    step(1'b1); push(1'b1);
    wait_sb("clean_rise", 30);
    chk("db_high_after_rise", btn_db, 1);
    step(1'b0); push(1'b0);
    wait_sb("clean_fall2", 30);
    chk("db_low_after_fall2", btn_db, 0);

    // Bounce: 3-cycle toggles for ~40 cycles, then hold high.
    for (int i = 0; i < 14; i++) begin
      step((i % 2) == 0);
      repeat (2) @(posedge clk);
    end
    chk("db_low_during_bounce", btn_db, 0);
    step(1'b1); push(1'b1);
    wait_sb("rise_after_bounce", 30);
    chk("db_high_after_bounce", btn_db, 1);
    step(1'b0); push(1'b0);
    wait_sb("fall_after_bounce", 30);

    // Glitch: 8 cycles high from ZERO is too short to be accepted.
    step(1'b1);
    repeat (7) @(posedge clk);
    step(1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_db", btn_db, 0);
    chk("glitch_state", int'(dut.state_q), int'(ZERO));

    // Reset in WAIT1 after two counted ticks; latency must restart.
    step(1'b1);
    n = 0;
    while (dut.stable_q != 2 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_wait1_two_ticks", int'(dut.state_q), int'(WAIT1));
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_db", btn_db, 0);
    chk("midreset_state", int'(dut.state_q), int'(ZERO));
    chk("midreset_stable", int'(dut.stable_q), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    push(1'b1);
    wait_sb("rise_after_midreset", 30);
    chk("db_high_after_midreset", btn_db, 1);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
